// File: rtl/register_file_param.sv
// Parametrised register file: 2 async read ports, 1 byte-enabled sync write port, sequenced clear.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module register_file_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              clr,
    output logic              busy,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [DATA_W-1:0] busW,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic              wr_drop
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned NBYTES = DATA_W / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;
    logic              dropNext;
    logic              zeroW;
    logic              wrEn;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] mem [DEPTH];

    // Write qualification shared by the array, the drop flag and forwarding
    assign zeroW = ZERO_REG && (Rw == '0);
    assign wrEn  = RegWr && (state == IDLE) && !zeroW;

    // Stored word with the enabled bytes of busW laid over it
    always_comb begin
        merged = mem[Rw];
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = busW[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state   <= CLEAR;
            ptr     <= '0;
            busy    <= 1'b1;
            wr_drop <= 1'b0;
        end else begin
            state   <= stateNext;
            ptr     <= ptrNext;
            busy    <= (stateNext == CLEAR);
            wr_drop <= dropNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        case (state)
            IDLE: begin
                if (clr) begin
                    stateNext = CLEAR;
                    ptrNext   = '0;
                end
            end
            CLEAR: begin
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    stateNext = IDLE;
                    ptrNext   = '0;
                end else begin
                    ptrNext = ptr + ADDR_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                ptrNext   = '0;
            end
        endcase
    end

    // Output logic: read ports and the drop indication
    always_comb begin
        busA     = '0;
        busB     = '0;
        dropNext = RegWr && (be != '0) && ((state == CLEAR) || zeroW);
        if (state == IDLE) begin
            busA = (ZERO_REG && (Ra == '0)) ? '0 : mem[Ra];
            busB = (ZERO_REG && (Rb == '0)) ? '0 : mem[Rb];
`ifdef REGFILE_BYPASS_EN
            if (wrEn && (Ra == Rw)) begin
                busA = merged;
            end
            if (wrEn && (Rb == Rw)) begin
                busB = merged;
            end
`endif
        end
    end

    // Storage array; left untouched while rstb is held low
    always_ff @(posedge clk) begin
        if (rstb) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (wrEn) begin
                mem[Rw] <= merged;
            end
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench for register_file_param: stimulus pushes expectations, a negedge monitor checks them.
module tb_register_file_param;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned NB    = 4;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          clr = 1'b0;
    logic          RegWr = 1'b0;
    logic [AW-1:0] Rw = '0;
    logic [AW-1:0] Ra = '0;
    logic [AW-1:0] Rb = '0;
    logic [DW-1:0] busW = '0;
    logic [NB-1:0] be = '0;
    logic          busy;
    logic          wr_drop;
    logic [DW-1:0] busA;
    logic [DW-1:0] busB;

    register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rstb(rstb), .clr(clr), .busy(busy),
        .RegWr(RegWr), .Rw(Rw), .busW(busW), .be(be),
        .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: compares every expectation due in the current cycle
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                0:       act = busA;
                1:       act = busB;
                2:       act = {31'b0, busy};
                default: act = {31'b0, wr_drop};
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h want=%h", e.tag, cyc, act, e.val);
            end
        end
    end

    // Reference model: array contents, clear progress, last cycle's drop
    logic [31:0] mem [DEPTH];
    bit          mBusy = 1'b1;
    int          mCnt = 0;
    bit          mDrop = 1'b0;
    bit          known = 1'b0;

    function automatic logic [31:0] mergeW(logic [31:0] old, logic [31:0] w, logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] expRead(logic [AW-1:0] a, bit wr, logic [AW-1:0] rw,
                                            logic [31:0] w, logic [3:0] b, bit drop);
        if (mBusy || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr && !drop && a == rw) return mergeW(mem[rw], w, b);
`endif
        return mem[a];
    endfunction

    task automatic push(int kind, logic [31:0] v, string tag);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.val = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zeroModel();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    endtask

    task automatic resetCycles(int n);
        for (int i = 0; i < n; i++) begin
            rstb = 1'b0; RegWr = 1'b0; clr = 1'b0;
            if (known) begin
                push(0, expRead(Ra, 1'b0, Rw, 32'h0, 4'h0, 1'b0), "rst busA");
                push(1, expRead(Rb, 1'b0, Rw, 32'h0, 4'h0, 1'b0), "rst busB");
                push(2, 32'(mBusy), "rst busy");
                push(3, 32'(mDrop), "rst wr_drop");
            end
            step();
            mBusy = 1'b1; mCnt = 0; mDrop = 1'b0; known = 1'b1;
            zeroModel();
        end
    endtask

    task automatic cycle(bit wr, logic [AW-1:0] rw, logic [31:0] w, logic [3:0] b,
                         logic [AW-1:0] ra, logic [AW-1:0] rb, bit c);
        bit drop;
        rstb = 1'b1; RegWr = wr; Rw = rw; busW = w; be = b; Ra = ra; Rb = rb; clr = c;
        drop = wr && (b != 0) && (mBusy || rw == 0);
        push(0, expRead(ra, wr, rw, w, b, drop), "busA");
        push(1, expRead(rb, wr, rw, w, b, drop), "busB");
        push(2, 32'(mBusy), "busy");
        push(3, 32'(mDrop), "wr_drop");
        step();
        mDrop = drop;
        if (mBusy) begin
            mCnt++;
            if (mCnt == DEPTH) mBusy = 1'b0;
        end else begin
            if (wr && !drop) mem[rw] = mergeW(mem[rw], w, b);
            if (c) begin
                mBusy = 1'b1; mCnt = 0;
                zeroModel();
            end
        end
    endtask

    initial begin
        zeroModel();
        // Reset then the initial clear, with a write attempted while busy
        resetCycles(2);
        for (int i = 0; i <= 32; i++) begin
            push(2, 32'(i < 32), "clear length");
            if (i == 5) push(3, 32'h1, "busy drop");
            cycle(i == 4, 5'd3, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 1'b0);
        end
        for (int a = 0; a < 32; a++) begin
            push(0, 32'h0, "cleared A");
            push(1, 32'h0, "cleared B");
            cycle(1'b0, 5'd0, 32'h0, 4'h0, AW'(a), AW'(31 - a), 1'b0);
        end
        // Full write then dual read
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd0, 5'd0, 1'b0);
        push(0, 32'hDEADBEEF, "full A");
        push(1, 32'hDEADBEEF, "full B");
        cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 1'b0);
        // Partial write
        cycle(1'b1, 5'd7, 32'h11223344, 4'hF, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 5'd0, 5'd0, 1'b0);
        push(0, 32'h11BB33DD, "partial");
        cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd0, 1'b0);
        // Zero register
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 1'b0);
        push(0, 32'h0, "zero read");
        push(3, 32'h1, "zero drop");
        cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0);
        push(3, 32'h0, "drop one-shot");
        cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0);
        // Clear mid-use, ignored clr, reset restart
        cycle(1'b1, 5'd9, 32'h12345678, 4'hF, 5'd0, 5'd0, 1'b0);
        push(0, 32'h12345678, "load9");
        cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9, 1'b1);
        for (int i = 1; i < 15; i++) begin
            push(2, 32'h1, "clr busy");
            cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9, i == 10);
        end
        resetCycles(1);
        for (int i = 0; i <= 32; i++) begin
            push(2, 32'(i < 32), "restart length");
            cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9, 1'b0);
        end
        push(0, 32'h0, "clr9");
        cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd0, 1'b0);
        // Same-cycle forwarding
        cycle(1'b1, 5'd4, 32'h0, 4'hF, 5'd0, 5'd0, 1'b0);
`ifdef REGFILE_BYPASS_EN
        push(0, 32'hCAFE0000, "bypass same");
`else
        push(0, 32'h0, "bypass same");
`endif
        cycle(1'b1, 5'd4, 32'hCAFEF00D, 4'b1100, 5'd4, 5'd0, 1'b0);
        push(0, 32'hCAFE0000, "bypass next");
        cycle(1'b0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 299);
            if (r == 0) resetCycles($urandom_range(1, 2));
            else cycle(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                       AW'($urandom), AW'($urandom), r < 5);
        end
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain left=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
